panda_risc_v_rst_sequencer: RTL and testbench

- Sequences release of DOM_N downstream reset domains (e.g. bus, peripherals, core) after the system reset deasserts, one domain at a time with a programmable gap.
- Services software requests: a partial (domain-mask) reset with quiesce handshake, or a full-system reset forwarded as a sw_reset pulse to the SoC reset-processing block.
- Sits between the reset-processing block (its sys_resetn drives this block's resetn) and the domain logic.

---
 rtl/panda_risc_v_rst_pkg.sv | 13 +
 rtl/panda_risc_v_rst_prio_pick.sv | 18 +
 rtl/panda_risc_v_rst_sequencer.sv | 167 ++++++++++++++++
 tb/tb_panda_risc_v_rst_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/panda_risc_v_rst_pkg.sv
// Shared constants for the reset sequencer: FSM encoding and counter widths.
package panda_risc_v_rst_pkg;

    localparam int unsigned RST_SEQ_CNT_W = 8;
    localparam int unsigned RST_SEQ_QTO_W = 16;

    localparam logic [2:0] RST_SEQ_RELEASE = 3'd0;
    localparam logic [2:0] RST_SEQ_RUN     = 3'd1;
    localparam logic [2:0] RST_SEQ_QUIESCE = 3'd2;
    localparam logic [2:0] RST_SEQ_ASSERT  = 3'd3;
    localparam logic [2:0] RST_SEQ_FULL    = 3'd4;

endpackage

// File: rtl/panda_risc_v_rst_prio_pick.sv
// Lowest-set-bit finder over the domains still waiting for release.
module panda_risc_v_rst_prio_pick
    import panda_risc_v_rst_pkg::*;
#(
    parameter int unsigned W = 3
)(
    input  logic [W-1:0] req,
    output logic [W-1:0] grant_c,
    output logic         valid_c
);

    // Two's-complement trick isolates the lowest set bit.
    always_comb begin
        grant_c = req & (~req + W'(1));
        valid_c = |req;
    end

endmodule

// File: rtl/panda_risc_v_rst_sequencer.sv
// Staggered domain reset release plus software partial/full reset handling.
// Optional quiesce watchdog: define PANDA_RST_SEQ_QUIESCE_TIMEOUT_EN.
module panda_risc_v_rst_sequencer
    import panda_risc_v_rst_pkg::*;
#(
    parameter int unsigned DOM_N       = 3,
    parameter int unsigned RELEASE_GAP = 8,
    parameter int unsigned HOLD_CYCLES = 16
`ifdef PANDA_RST_SEQ_QUIESCE_TIMEOUT_EN
    ,
    parameter int unsigned QUIESCE_TIMEOUT = 256
`endif
)(
    input  logic             clk,
    input  logic             resetn,
    input  logic             part_rst_req,
    input  logic [DOM_N-1:0] part_rst_mask,
    input  logic             full_rst_req,
    output logic             busy,
    output logic [DOM_N-1:0] quiesce_req,
    input  logic [DOM_N-1:0] quiesce_ack,
    output logic [DOM_N-1:0] dom_resetn,
    output logic             sw_reset,
    output logic             timeout_flag
);

    logic [2:0]               state, state_nxt;
    logic [RST_SEQ_CNT_W-1:0] cnt, cnt_nxt;
    logic [DOM_N-1:0]         mask_q, mask_nxt;
    logic [DOM_N-1:0]         rem_q, rem_nxt;
    logic [DOM_N-1:0]         dom_nxt;
    logic [DOM_N-1:0]         qreq_nxt;
    logic                     sw_nxt;
    logic                     busy_nxt;
    logic                     quiesce_done;
    logic [DOM_N-1:0]         pick_grant;
    logic                     pick_valid;

`ifdef PANDA_RST_SEQ_QUIESCE_TIMEOUT_EN
    logic [RST_SEQ_QTO_W-1:0] qto_cnt, qto_cnt_nxt;
    logic                     timeout_nxt;
`endif

    panda_risc_v_rst_prio_pick #(
        .W (DOM_N)
    ) u_prio_pick (
        .req     (rem_q),
        .grant_c (pick_grant),
        .valid_c (pick_valid)
    );

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        mask_nxt     = mask_q;
        rem_nxt      = rem_q;
        dom_nxt      = dom_resetn;
        sw_nxt       = sw_reset;
        quiesce_done = ((quiesce_ack & mask_q) == mask_q);
`ifdef PANDA_RST_SEQ_QUIESCE_TIMEOUT_EN
        qto_cnt_nxt  = qto_cnt;
        timeout_nxt  = timeout_flag;
`endif

        case (state)
            RST_SEQ_RELEASE: begin
                // Empty remaining mask means the last masked domain went out last cycle.
                if (!pick_valid) begin
                    state_nxt = RST_SEQ_RUN;
                    cnt_nxt   = '0;
                end else if (cnt == RST_SEQ_CNT_W'(RELEASE_GAP - 1)) begin
                    dom_nxt = dom_resetn | pick_grant;
                    rem_nxt = rem_q & ~pick_grant;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + RST_SEQ_CNT_W'(1);
                end
            end
            RST_SEQ_RUN: begin
                if (full_rst_req) begin
                    state_nxt = RST_SEQ_FULL;
                    sw_nxt    = 1'b1;
                end else if (part_rst_req && (part_rst_mask != '0)) begin
                    state_nxt = RST_SEQ_QUIESCE;
                    mask_nxt  = part_rst_mask;
`ifdef PANDA_RST_SEQ_QUIESCE_TIMEOUT_EN
                    qto_cnt_nxt = '0;
                    timeout_nxt = 1'b0;
`endif
                end
            end
            RST_SEQ_QUIESCE: begin
`ifdef PANDA_RST_SEQ_QUIESCE_TIMEOUT_EN
                // Give up on stuck domains and reset them anyway.
                if (!quiesce_done) begin
                    if (qto_cnt == RST_SEQ_QTO_W'(QUIESCE_TIMEOUT - 1)) begin
                        quiesce_done = 1'b1;
                        timeout_nxt  = 1'b1;
                    end else begin
                        qto_cnt_nxt = qto_cnt + RST_SEQ_QTO_W'(1);
                    end
                end
`endif
                if (quiesce_done) begin
                    state_nxt = RST_SEQ_ASSERT;
                    dom_nxt   = dom_resetn & ~mask_q;
                    cnt_nxt   = '0;
                end
            end
            RST_SEQ_ASSERT: begin
                if (cnt == RST_SEQ_CNT_W'(HOLD_CYCLES - 1)) begin
                    state_nxt = RST_SEQ_RELEASE;
                    cnt_nxt   = '0;
                    rem_nxt   = mask_q;
                end else begin
                    cnt_nxt = cnt + RST_SEQ_CNT_W'(1);
                end
            end
            RST_SEQ_FULL: begin
                sw_nxt = 1'b1;
            end
            default: begin
                state_nxt = RST_SEQ_RELEASE;
            end
        endcase

        qreq_nxt = (state_nxt == RST_SEQ_QUIESCE) ? mask_nxt : '0;
        busy_nxt = (state_nxt != RST_SEQ_RUN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= RST_SEQ_RELEASE;
            cnt         <= '0;
            mask_q      <= '1;
            rem_q       <= '1;
            dom_resetn  <= '0;
            quiesce_req <= '0;
            sw_reset    <= 1'b0;
            busy        <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            mask_q      <= mask_nxt;
            rem_q       <= rem_nxt;
            dom_resetn  <= dom_nxt;
            quiesce_req <= qreq_nxt;
            sw_reset    <= sw_nxt;
            busy        <= busy_nxt;
        end
    end

`ifdef PANDA_RST_SEQ_QUIESCE_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            qto_cnt      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            qto_cnt      <= qto_cnt_nxt;
            timeout_flag <= timeout_nxt;
        end
    end
`else
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_panda_risc_v_rst_sequencer.sv
// Scoreboard bench for the reset sequencer; define PANDA_RST_SEQ_QUIESCE_TIMEOUT_EN for the watchdog build.
module tb_panda_risc_v_rst_sequencer;

    localparam int DOM_N = 3;
    localparam int GAP   = 8;
    localparam int HOLD  = 16;
    localparam int QTO   = 256;

    typedef struct packed {
        logic [DOM_N-1:0] dom;
        logic [DOM_N-1:0] qreq;
        logic             busy;
        logic             sw;
        logic             tflag;
    } obs_t;

    logic             clk = 1'b0;
    logic             resetn;
    logic             part_rst_req;
    logic [DOM_N-1:0] part_rst_mask;
    logic             full_rst_req;
    logic             busy;
    logic [DOM_N-1:0] quiesce_req;
    logic [DOM_N-1:0] quiesce_ack;
    logic [DOM_N-1:0] dom_resetn;
    logic             sw_reset;
    logic             timeout_flag;

    int   tests_run    = 0;
    int   tests_failed = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    panda_risc_v_rst_sequencer #(
        .DOM_N       (DOM_N),
        .RELEASE_GAP (GAP),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .part_rst_req  (part_rst_req),
        .part_rst_mask (part_rst_mask),
        .full_rst_req  (full_rst_req),
        .busy          (busy),
        .quiesce_req   (quiesce_req),
        .quiesce_ack   (quiesce_ack),
        .dom_resetn    (dom_resetn),
        .sw_reset      (sw_reset),
        .timeout_flag  (timeout_flag)
    );

    function automatic obs_t obs_now();
        obs_t o;
        o.dom   = dom_resetn;
        o.qreq  = quiesce_req;
        o.busy  = busy;
        o.sw    = sw_reset;
        o.tflag = timeout_flag;
        return o;
    endfunction

    function automatic obs_t mk(logic [DOM_N-1:0] d, logic [DOM_N-1:0] q, logic b, logic s, logic t);
        obs_t o;
        o.dom = d; o.qreq = q; o.busy = b; o.sw = s; o.tflag = t;
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t e, g;
        resetn = 1'b0; part_rst_req = 1'b0; part_rst_mask = '0;
        full_rst_req = 1'b0; quiesce_ack = '0;
        exp_q.push_back(mk('0, '0, 1'b1, 1'b0, 1'b0));
        repeat (3) step();
        e = exp_q.pop_front(); g = obs_now(); tests_run++;
        if (g !== e) begin
            tests_failed++;
            $display("FAIL reset: got {dom,qreq,busy,sw,tflag}=%b want %b", g, e);
        end
    endtask

    // Releases resetn and checks staggered release; requests during RELEASE must be dropped.
    task automatic test_power_on();
        obs_t e, g;
        for (int k = 1; k <= DOM_N*GAP + 2; k++) begin
            e = '0;
            for (int i = 0; i < DOM_N; i++) e.dom[i] = (k >= (i+1)*GAP);
            e.busy = (k <= DOM_N*GAP);
            exp_q.push_back(e);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 1; k <= DOM_N*GAP + 2; k++) begin
            if (k == 3 || k == 12) begin
                part_rst_req = 1'b1; part_rst_mask = '1; full_rst_req = 1'b1;
            end
            step();
            part_rst_req = 1'b0; part_rst_mask = '0; full_rst_req = 1'b0;
            e = exp_q.pop_front(); g = obs_now(); tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL power_on cyc=%0d: got {dom,qreq,busy,sw,tflag}=%b want %b", k, g, e);
            end
        end
    endtask

    task automatic test_partial();
        obs_t e, g;
        int   ack_at, rel_at;
        ack_at = 5;
        rel_at = ack_at + HOLD + GAP;
        for (int j = 0; j <= rel_at + 2; j++) begin
            e = mk(3'b111, '0, (j <= rel_at), 1'b0, 1'b0);
            if (j < ack_at) e.qreq = 3'b100;
            if (j >= ack_at && j < rel_at) e.dom = 3'b011;
            exp_q.push_back(e);
        end
        part_rst_req = 1'b1; part_rst_mask = 3'b100;
        for (int j = 0; j <= rel_at + 2; j++) begin
            step();
            part_rst_req = 1'b0; part_rst_mask = '0;
            e = exp_q.pop_front(); g = obs_now(); tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL partial cyc=%0d: got {dom,qreq,busy,sw,tflag}=%b want %b", j, g, e);
            end
            if (j == ack_at - 1) quiesce_ack = 3'b100;
        end
        quiesce_ack = '0;
    endtask

    task automatic test_zero_mask();
        obs_t e, g;
        for (int j = 0; j < 4; j++) exp_q.push_back(mk(3'b111, '0, 1'b0, 1'b0, 1'b0));
        part_rst_req = 1'b1; part_rst_mask = '0;
        for (int j = 0; j < 4; j++) begin
            step();
            part_rst_req = 1'b0;
            e = exp_q.pop_front(); g = obs_now(); tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL zero_mask cyc=%0d: got {dom,qreq,busy,sw,tflag}=%b want %b", j, g, e);
            end
        end
    endtask

    task automatic test_full_priority();
        obs_t e, g;
        for (int j = 0; j < 4; j++) exp_q.push_back(mk(3'b111, '0, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(mk('0, '0, 1'b1, 1'b0, 1'b0));
        full_rst_req = 1'b1; part_rst_req = 1'b1; part_rst_mask = 3'b011;
        for (int j = 0; j < 4; j++) begin
            step();
            full_rst_req = 1'b0; part_rst_req = 1'b0; part_rst_mask = '0;
            e = exp_q.pop_front(); g = obs_now(); tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL full_prio cyc=%0d: got {dom,qreq,busy,sw,tflag}=%b want %b", j, g, e);
            end
        end
        #2 resetn = 1'b0;
        #1;
        e = exp_q.pop_front(); g = obs_now(); tests_run++;
        if (g !== e) begin
            tests_failed++;
            $display("FAIL full_reset_clear: got {dom,qreq,busy,sw,tflag}=%b want %b", g, e);
        end
    endtask

    task automatic test_abort_assert();
        obs_t e, g;
        exp_q.push_back(mk(3'b111, 3'b011, 1'b1, 1'b0, 1'b0));
        for (int j = 1; j < 5; j++) exp_q.push_back(mk(3'b100, '0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk('0, '0, 1'b1, 1'b0, 1'b0));
        quiesce_ack = 3'b011;
        part_rst_req = 1'b1; part_rst_mask = 3'b011;
        for (int j = 0; j < 5; j++) begin
            step();
            part_rst_req = 1'b0; part_rst_mask = '0;
            e = exp_q.pop_front(); g = obs_now(); tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL abort_assert cyc=%0d: got {dom,qreq,busy,sw,tflag}=%b want %b", j, g, e);
            end
        end
        #2 resetn = 1'b0;
        #1;
        quiesce_ack = '0;
        e = exp_q.pop_front(); g = obs_now(); tests_run++;
        if (g !== e) begin
            tests_failed++;
            $display("FAIL abort_reset: got {dom,qreq,busy,sw,tflag}=%b want %b", g, e);
        end
    endtask

    task automatic test_quiesce_timeout();
        obs_t e, g;
        int   n;
`ifdef PANDA_RST_SEQ_QUIESCE_TIMEOUT_EN
        n = QTO + HOLD + GAP + 3;
        for (int j = 0; j < n; j++) begin
            if (j < QTO) e = mk(3'b111, 3'b001, 1'b1, 1'b0, 1'b0);
            else         e = mk((j < QTO + HOLD + GAP) ? 3'b110 : 3'b111, '0,
                                (j <= QTO + HOLD + GAP), 1'b0, 1'b1);
            exp_q.push_back(e);
        end
        exp_q.push_back(mk(3'b111, 3'b010, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(3'b101, '0, 1'b1, 1'b0, 1'b0));
`else
        n = 300;
        for (int j = 0; j < n + 2; j++) exp_q.push_back(mk(3'b111, 3'b001, 1'b1, 1'b0, 1'b0));
`endif
        exp_q.push_back(mk('0, '0, 1'b1, 1'b0, 1'b0));
        quiesce_ack = '0;
        part_rst_req = 1'b1; part_rst_mask = 3'b001;
        for (int j = 0; j < n; j++) begin
            step();
            part_rst_req = 1'b0; part_rst_mask = '0;
            e = exp_q.pop_front(); g = obs_now(); tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL quiesce_wait cyc=%0d: got {dom,qreq,busy,sw,tflag}=%b want %b", j, g, e);
            end
        end
        // Second request: accepted with the watchdog build, dropped (still busy) otherwise.
        quiesce_ack = 3'b010;
        part_rst_req = 1'b1; part_rst_mask = 3'b010;
        for (int j = 0; j < 2; j++) begin
            step();
            part_rst_req = 1'b0; part_rst_mask = '0;
            e = exp_q.pop_front(); g = obs_now(); tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL quiesce_next cyc=%0d: got {dom,qreq,busy,sw,tflag}=%b want %b", j, g, e);
            end
        end
        #2 resetn = 1'b0;
        #1;
        quiesce_ack = '0;
        e = exp_q.pop_front(); g = obs_now(); tests_run++;
        if (g !== e) begin
            tests_failed++;
            $display("FAIL quiesce_reset: got {dom,qreq,busy,sw,tflag}=%b want %b", g, e);
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_partial();
        test_zero_mask();
        test_full_priority();
        test_power_on();
        test_abort_assert();
        test_power_on();
        test_quiesce_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
